// File: rtl/sr_debounce_ctrl_if.sv
// Raw set/reset requests in, conditioned SR state and strobes out.
interface sr_debounce_ctrl_if;
    logic s_raw;
    logic r_raw;
    logic s_clean;
    logic r_clean;
    logic set_pulse;
    logic reset_pulse;
    logic q;
    logic qbar;
    logic conflict;

    modport master (
        output s_raw, r_raw,
        input  s_clean, r_clean, set_pulse, reset_pulse,
        input  q, qbar, conflict
    );

    modport slave (
        input  s_raw, r_raw,
        output s_clean, r_clean, set_pulse, reset_pulse,
        output q, qbar, conflict
    );
endinterface

// File: rtl/sr_debounce_ctrl.sv
// Synchronise, debounce and resolve raw set/reset into a registered q/qbar.
module sr_debounce_ctrl #(
    parameter int CNT_W    = 16,
    parameter int DEBOUNCE = 50000,
    parameter int PRIO     = 0
) (
    input logic             clk,
    input logic             rst_n,
    sr_debounce_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    // Bit 0 is the set channel, bit 1 the reset channel.
    logic [1:0]       raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       clean_q;
    logic [1:0]       clean_d;
    logic [1:0]       pulse_q;
    logic [1:0]       pulse_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             state_q;
    logic             state_d;
    logic             conflict_q;
    logic             conflict_d;
    logic             s_c;
    logic             r_c;

    assign raw = {bus.r_raw, bus.s_raw};
    assign s_c = clean_q[0];
    assign r_c = clean_q[1];

    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        pulse_d = clean_d & ~clean_q;
    end

    // Both-high resolution; unknown PRIO values fall back to reset-wins.
    always_comb begin
        state_d    = state_q;
        conflict_d = s_c & r_c;
        unique case (1'b1)
            (s_c & ~r_c): state_d = 1'b1;
            (~s_c & r_c): state_d = 1'b0;
            (s_c & r_c): begin
                if (PRIO == 1) begin
                    state_d = 1'b1;
                end else if (PRIO == 2) begin
                    state_d = state_q;
                end else begin
                    state_d = 1'b0;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            clean_q    <= '0;
            pulse_q    <= '0;
            cnt_q      <= '{default: '0};
            state_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            clean_q    <= clean_d;
            pulse_q    <= pulse_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.s_clean     = clean_q[0];
    assign bus.r_clean     = clean_q[1];
    assign bus.set_pulse   = pulse_q[0];
    assign bus.reset_pulse = pulse_q[1];
    assign bus.q           = state_q;
    assign bus.qbar        = ~state_q;
    assign bus.conflict    = conflict_q;

endmodule

// File: tb/tb_sr_debounce_ctrl.sv
// Bench for sr_debounce_ctrl: event scoreboard on PRIO=0, direct checks on PRIO=1/2.
module tb_sr_debounce_ctrl;

    logic clk;
    logic rst_n;
    logic s_raw;
    logic r_raw;
    int   cyc;
    int   n_chk;
    int   n_err;
    bit   mon_en;

    // Expected output changes: {cycle, signal id, new value}.
    logic [31:0] sb_q[$];
    logic [6:0]  prev;
    logic [6:0]  cur;

    logic m_s;
    logic m_r;
    logic m_q;
    logic m_conf;

    sr_debounce_ctrl_if if0 ();
    sr_debounce_ctrl_if if1 ();
    sr_debounce_ctrl_if if2 ();

    assign if0.s_raw = s_raw;
    assign if0.r_raw = r_raw;
    assign if1.s_raw = s_raw;
    assign if1.r_raw = r_raw;
    assign if2.s_raw = s_raw;
    assign if2.r_raw = r_raw;

    sr_debounce_ctrl #(.CNT_W(8), .DEBOUNCE(4), .PRIO(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    sr_debounce_ctrl #(.CNT_W(8), .DEBOUNCE(4), .PRIO(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );
    sr_debounce_ctrl #(.CNT_W(8), .DEBOUNCE(4), .PRIO(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input int cy, input int sig,
                                       input logic val);
        return {cy[23:0], sig[3:0], 3'b000, val};
    endfunction

    task automatic push(input int cy, input int sig, input logic val);
        sb_q.push_back(ev(cy, sig, val));
    endtask

    assign cur = {if0.conflict, if0.qbar, if0.q, if0.reset_pulse,
                  if0.set_pulse, if0.r_clean, if0.s_clean};

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 7; i++) begin
                if (cur[i] !== prev[i]) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected", ev(cyc, i, cur[i]), 32'hdeaddead);
                    end else begin
                        chk("sb_event", ev(cyc, i, cur[i]), sb_q.pop_front());
                    end
                end
            end
        end
        prev <= cur;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Drive steady raw levels and queue the resulting DUT0 output changes.
    task automatic step_raw(input logic s, input logic r,
                            input logic exp_q, input logic exp_conf);
        int c;
        tick(1);
        c     = cyc;
        s_raw = s;
        r_raw = r;
        if (s != m_s) push(c + 6, 0, s);
        if (r != m_r) push(c + 6, 1, r);
        if (s && !m_s) push(c + 6, 2, 1'b1);
        if (r && !m_r) push(c + 6, 3, 1'b1);
        if (s && !m_s) push(c + 7, 2, 1'b0);
        if (r && !m_r) push(c + 7, 3, 1'b0);
        if (exp_q != m_q) begin
            push(c + 7, 4, exp_q);
            push(c + 7, 5, ~exp_q);
        end
        if (exp_conf != m_conf) push(c + 7, 6, exp_conf);
        m_s    = s;
        m_r    = r;
        m_q    = exp_q;
        m_conf = exp_conf;
        tick(10);
    endtask

    task automatic expect_set_after_release();
        int c2;
        c2 = cyc;
        push(c2 + 6, 0, 1'b1);
        push(c2 + 6, 2, 1'b1);
        push(c2 + 7, 2, 1'b0);
        push(c2 + 7, 4, 1'b1);
        push(c2 + 7, 5, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        s_raw  = 1'b0;
        r_raw  = 1'b0;
        m_s    = 1'b0;
        m_r    = 1'b0;
        m_q    = 1'b0;
        m_conf = 1'b0;

        tick(3);
        chk("rst_q", 32'(if0.q), 32'd0);
        chk("rst_qbar", 32'(if0.qbar), 32'd1);
        chk("rst_clean", 32'({if0.s_clean, if0.r_clean}), 32'd0);
        chk("rst_pulse", 32'({if0.set_pulse, if0.reset_pulse}), 32'd0);
        chk("rst_conflict", 32'(if0.conflict), 32'd0);
        rst_n = 1'b1;
        tick(3);
        mon_en = 1'b1;

        // Set, then release set: q holds at 1.
        step_raw(1'b1, 1'b0, 1'b1, 1'b0);
        step_raw(1'b0, 1'b0, 1'b1, 1'b0);

        // Short bursts never reach the debounce threshold.
        for (int k = 0; k < 5; k++) begin
            s_raw = 1'b1;
            tick(3);
            s_raw = 1'b0;
            tick(3);
        end
        tick(8);

        // Both high with q=1.
        step_raw(1'b1, 1'b1, 1'b0, 1'b1);
        chk("p1_q_conf_q1", 32'(if1.q), 32'd1);
        chk("p2_q_conf_q1", 32'(if2.q), 32'd1);
        chk("p1_conflict", 32'(if1.conflict), 32'd1);
        chk("p2_conflict", 32'(if2.conflict), 32'd1);
        chk("qbar_conf", 32'(if0.qbar), 32'd1);
        step_raw(1'b0, 1'b0, 1'b0, 1'b0);

        // Set then reset alone.
        step_raw(1'b1, 1'b0, 1'b1, 1'b0);
        step_raw(1'b0, 1'b0, 1'b1, 1'b0);
        step_raw(1'b0, 1'b1, 1'b0, 1'b0);
        step_raw(1'b0, 1'b0, 1'b0, 1'b0);
        chk("p1_q_after_r", 32'(if1.q), 32'd0);
        chk("p2_q_after_r", 32'(if2.q), 32'd0);

        // Both high with q=0.
        step_raw(1'b1, 1'b1, 1'b0, 1'b1);
        chk("p1_q_conf_q0", 32'(if1.q), 32'd1);
        chk("p2_q_conf_q0", 32'(if2.q), 32'd0);
        step_raw(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset at count 2 of a set debounce discards the partial count.
        tick(1);
        s_raw = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        expect_set_after_release();
        tick(10);

        // Asynchronous reset between edges with q=1, s_raw held high.
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_q", 32'(if0.q), 32'd0);
        chk("arst_qbar", 32'(if0.qbar), 32'd1);
        chk("arst_s_clean", 32'(if0.s_clean), 32'd0);
        chk("arst_pulse", 32'({if0.set_pulse, if0.reset_pulse}), 32'd0);
        chk("arst_p1_q", 32'(if1.q), 32'd0);
        tick(2);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        expect_set_after_release();
        m_s = 1'b1;
        m_q = 1'b1;
        tick(10);

        step_raw(1'b0, 1'b0, 1'b1, 1'b0);
        chk("final_qbar", 32'(if0.qbar), 32'd0);

        tick(5);
        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sr_debounce_ctrl.md
SR_DEBOUNCE_CTRL -- requirements
Module: sr_debounce_ctrl

Purpose: upstream conditioning stage for SR-style storage. Turns noisy raw set/reset inputs into debounced, conflict-resolved, registered q/qbar.

Interface
REQ-001 Parameter CNT_W, default 16: debounce counter width in bits.
REQ-002 Parameter DEBOUNCE, default 50000: number of cycles an input must be stable before it is accepted; legal range 1..2^CNT_W-1.
REQ-003 Parameter PRIO, default 0: resolution when both clean inputs are high; 0 = reset wins, 1 = set wins, 2 = hold.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_raw  input  1  raw set request; asynchronous to clk, may bounce.
REQ-007 r_raw  input  1  raw reset request; asynchronous to clk, may bounce.
REQ-008 s_clean  output  1  debounced set level.
REQ-009 r_clean  output  1  debounced reset level.
REQ-010 set_pulse  output  1  one-cycle strobe on each s_clean 0->1 transition.
REQ-011 reset_pulse  output  1  one-cycle strobe on each r_clean 0->1 transition.
REQ-012 q  output  1  stored state.
REQ-013 qbar  output  1  complement of q.
REQ-014 conflict  output  1  high while s_clean and r_clean are both 1.

Function
REQ-015 Each raw input SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-016 Each channel SHALL keep a CNT_W-bit counter, updated every edge, per REQ-017 to REQ-019.
REQ-017 If sync2 equals clean, the counter SHALL clear to 0.
REQ-018 If sync2 differs from clean and counter != DEBOUNCE-1, the counter SHALL increment by 1.
REQ-019 If sync2 differs from clean and counter == DEBOUNCE-1, clean SHALL take sync2 and the counter SHALL clear to 0.
REQ-020 A raw change held steady from before edge k SHALL update clean at edge k+1+DEBOUNCE (2-flop synchronizer plus DEBOUNCE cycles).
REQ-021 A pulse or glitch whose sync2 image lasts fewer than DEBOUNCE cycles SHALL never change clean.
REQ-022 set_pulse and reset_pulse SHALL be registered and SHALL be high exactly for the cycle following the edge at which the clean level rose; they SHALL never be high for a falling transition.
REQ-023 q SHALL update one edge after the clean levels, from the decision applied to (s_clean, r_clean) in REQ-024 to REQ-026.
REQ-024 For (s_clean, r_clean) = 00, q SHALL hold; for 01, q SHALL become 0; for 10, q SHALL become 1.
REQ-025 For (s_clean, r_clean) = 11, q SHALL become 0 when PRIO=0, become 1 when PRIO=1, and hold when PRIO=2.
REQ-026 Any other PRIO value SHALL behave as PRIO=0.
REQ-027 conflict SHALL be registered alongside q: high in every cycle whose q update used 11.
REQ-028 qbar SHALL equal ~q in every cycle, including during reset; q and qbar are never equal.
REQ-029 The two channels SHALL be fully independent; simultaneous clean transitions on both SHALL be handled in one step per REQ-024 to REQ-025.
REQ-030 The counter SHALL never exceed DEBOUNCE-1 and SHALL not wrap.

Reset
REQ-031 rst_n low SHALL immediately, with no clock edge, force: sync flops, counters, s_clean, r_clean, set_pulse, reset_pulse, q and conflict to 0, and qbar to 1.
REQ-032 Reset asserted mid-count SHALL discard the partial count; after release, the full DEBOUNCE interval SHALL be required.
REQ-033 Raw inputs held high through reset release SHALL be treated as new transitions and produce pulses per REQ-020 and REQ-022.

Verification (DEBOUNCE=4, PRIO=0 unless stated)
REQ-034 Drive rst_n=0 between edges with q=1 -> q=0, qbar=1, pulses 0 before the next edge.
REQ-035 s_raw 0->1 held from before edge 0 -> s_clean=1 after edge 5, set_pulse high only in the cycle after edge 5, q=1 after edge 6.
REQ-036 s_raw high for 3 cycles then low, repeated 5 times -> s_clean, set_pulse and q never change.
REQ-037 With q=1, hold r_raw and s_raw both high -> conflict=1 and q=0; repeat with PRIO=1 -> q=1; with PRIO=2 -> q unchanged.
REQ-038 Pulse rst_n low at count 2 of a set debounce while s_raw stays high -> after release, s_clean rises at edge 1+4 counted from the first post-release edge.
REQ-039 Set q=1, then drop s_raw -> s_clean falls after 5 edges, no set_pulse, q stays 1 (hold).
